pic_fetch_unit: RTL

Instruction fetch and sequencing stage that consumes program-counter addresses and produces instructions for the PIC16F887 model. It drives a synchronous program ROM and presents one 14-bit instruction per clock to execute. It handles redirects (GOTO, CALL, RETURN, interrupt) with a one-bubble flush, which reproduces the PIC 2-cycle branch timing. It owns the 8-level circular hardware return stack.

---
 rtl/pic_pkg.sv | 15 +
 rtl/return_stack.sv | 59 +++++
 rtl/pic_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC16F887 core model.
//   PC_W / pc_t       : program counter and ROM address width (13 bits)
//   INSTR_W / instr_t : instruction word width (14 bits)
//   RESET_VECTOR      : first fetch address after reset
//   INT_VECTOR        : interrupt redirect address
package pic_pkg;
  localparam int PC_W    = 13;
  localparam int INSTR_W = 14;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam pc_t RESET_VECTOR = 13'h0000;
  localparam pc_t INT_VECTOR   = 13'h0004;
endpackage

// File: rtl/return_stack.sv
// Circular hardware return stack (PIC style: no real limit, it just wraps).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_data : write push_data at sp, advance sp
//   pop             : retreat sp; caller reads top in the same cycle
//   top             : entry at sp-1 (the value a pop returns)
//   overflow        : one-cycle pulse after a push made while full
//   underflow       : one-cycle pulse after a pop made while empty
// push and pop are mutually exclusive; push wins if both are asserted.
module return_stack
  import pic_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  pc_t  push_data,
  input  logic pop,
  output pc_t  top,
  output logic overflow,
  output logic underflow
);
  localparam int SP_W    = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = SP_W + 1;

  pc_t               stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_m1;
  logic [DEPTH_W-1:0] depth;

  assign sp_m1 = sp - SP_W'(1);
  // Wraps even when empty: an underflowing pop returns the stale circular entry.
  assign top   = stack[sp_m1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
      sp        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (push) begin
        stack[sp] <= push_data;
        sp        <= sp + SP_W'(1);
        // When full the oldest entry is silently overwritten.
        if (depth == DEPTH_W'(STACK_DEPTH)) overflow <= 1'b1;
        else                                 depth    <= depth + DEPTH_W'(1);
      end else if (pop) begin
        sp <= sp_m1;
        if (depth == '0) underflow <= 1'b1;
        else             depth     <= depth - DEPTH_W'(1);
      end
    end
  end
endmodule

// File: rtl/pic_fetch_unit.sv
// Instruction fetch / sequencing stage for the PIC16F887 model.
// Drives a synchronous program ROM (data returns one cycle after the
// address) and presents one instruction per clock to execute. Redirects
// flush the sequential fetch in flight, giving one bubble (PIC 2-cycle
// branch timing). Owns the circular return stack.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   imem_addr          : ROM read address (combinational)
//   imem_data          : ROM data for last cycle's imem_addr
//   instr, instr_pc    : current instruction and its address
//   instr_valid        : instr is valid for execute
//   stall              : execute not consuming; instr holds
//   branch_en, call_en : jump / call to branch_target
//   ret_en             : pop return address
//   irq_take           : interrupt; pushes instr_pc, jumps to INT_VECTOR
//   stk_overflow/underflow : one-cycle return stack error pulses
module pic_fetch_unit
  import pic_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  output pc_t    imem_addr,
  input  instr_t imem_data,
  output instr_t instr,
  output pc_t    instr_pc,
  output logic   instr_valid,
  input  logic   stall,
  input  logic   branch_en,
  input  logic   call_en,
  input  logic   ret_en,
  input  logic   irq_take,
  input  pc_t    branch_target,
  output logic   stk_overflow,
  output logic   stk_underflow
);
  pc_t  pc_q;
  pc_t  fetch_pc_q;
  logic fetch_valid_q;

  logic consume;
  logic redirect;
  logic push;
  logic pop;
  pc_t  push_data;
  pc_t  stk_top;
  pc_t  target;

  assign instr       = imem_data;
  assign instr_pc    = fetch_pc_q;
  assign instr_valid = fetch_valid_q;

  // On stall the ROM re-reads the current address so instr holds.
  assign imem_addr = stall ? fetch_pc_q : pc_q;
  assign consume   = fetch_valid_q & ~stall;

  // Redirect priority: irq > ret > call > branch; only a consumed instruction redirects.
  always_comb begin
    redirect  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = fetch_pc_q;
    target    = branch_target;
    if (consume) begin
      redirect = 1'b1;
      if (irq_take) begin
        push      = 1'b1;
        push_data = fetch_pc_q;
        target    = INT_VECTOR;
      end else if (ret_en) begin
        pop    = 1'b1;
        target = stk_top;
      end else if (call_en) begin
        push      = 1'b1;
        push_data = fetch_pc_q + pc_t'(1);
        target    = branch_target;
      end else if (!branch_en) begin
        redirect = 1'b0;
      end
    end
  end

  // Fetch stage boundary: pc_q is the address in flight to the ROM,
  // fetch_pc_q/fetch_valid_q describe the word the ROM is returning now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      fetch_pc_q    <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
    end else if (redirect) begin
      pc_q          <= target;
      fetch_valid_q <= 1'b0;
    end else if (!stall) begin
      fetch_pc_q    <= pc_q;
      fetch_valid_q <= 1'b1;
      pc_q          <= pc_q + pc_t'(1);
    end
  end

  return_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .top       (stk_top),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );
endmodule
